// File: rtl/shift_arbiter_32b.sv
// shift_arbiter_32b: round-robin sequencer sharing one right barrel shifter for SRL/SRA/SLL; optional macro SHIFT_ARB_ZERO_BYPASS_EN skips EXEC for shamt=0 or illegal ops

module barrel_shifter_right_32b (
  input  logic [31:0] data,
  input  logic [4:0]  cntrl,
  input  logic        arith,
  output logic [31:0] result
);
  logic        fill;
  logic [31:0] stage [6];
  assign fill = arith & data[31];
  assign stage[0] = data;
  for (genvar i = 0; i < 5; i++) begin : g_stage
    localparam int K = 1 << i;
    assign stage[i+1] = cntrl[i] ? {{K{fill}}, stage[i][31:K]} : stage[i];
  end
  assign result = stage[5];
endmodule

module shift_arbiter_32b #(
  parameter bit PRIO_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req0_op,
  input  logic [31:0] req0_data,
  input  logic [4:0]  req0_shamt,
  input  logic [1:0]  req1_op,
  input  logic [31:0] req1_data,
  input  logic [4:0]  req1_shamt,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_id,
  output logic        resp_err
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t      state, state_nxt;
  logic        prio;
  logic [1:0]  op;
  logic [31:0] data;
  logic [4:0]  shamt;
  logic        id;
  logic [1:0]  grant;
  logic        take, gid, byp;
  logic [1:0]  sel_op;
  logic [31:0] sel_data;
  logic [4:0]  sel_shamt;
  logic [31:0] sh_in, sh_out, result;
  barrel_shifter_right_32b u_shift (
    .data   (sh_in),
    .cntrl  (shamt),
    .arith  (op == 2'b01),
    .result (sh_out)
  );
  // SLL reuses the right shifter by reversing bits on the way in and out
  assign sh_in  = (op == 2'b10) ? {<<{data}} : data;
  assign result = (op == 2'b11) ? data : (op == 2'b10) ? {<<{sh_out}} : sh_out;
  assign take      = |grant;
  assign gid       = grant[1];
  assign sel_op    = gid ? req1_op : req0_op;
  assign sel_data  = gid ? req1_data : req0_data;
  assign sel_shamt = gid ? req1_shamt : req0_shamt;
`ifdef SHIFT_ARB_ZERO_BYPASS_EN
  assign byp = (sel_shamt == 5'd0) || (sel_op == 2'b11);
`else
  assign byp = 1'b0;
`endif
  assign req_ready  = grant;
  assign resp_valid = (state == RESP);
  // Arbitration in IDLE: lone requester wins, contention goes to prio
  always_comb begin
    grant = 2'b00;
    if (state == IDLE && !rst)
      grant = (req_valid == 2'b11) ? (prio ? 2'b10 : 2'b01) : req_valid;
  end
  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (state == IDLE)      state_nxt = take ? (byp ? RESP : EXEC) : IDLE;
    else if (state == EXEC) state_nxt = RESP;
    else if (state == RESP) state_nxt = resp_ready ? IDLE : RESP;
  end
  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end
  // Request latch, round-robin pointer and registered response
  always_ff @(posedge clk) begin
    if (rst) begin
      prio      <= PRIO_INIT;
      op        <= 2'b00;
      data      <= 32'd0;
      shamt     <= 5'd0;
      id        <= 1'b0;
      resp_data <= 32'd0;
      resp_id   <= 1'b0;
      resp_err  <= 1'b0;
    end else if (take) begin
      prio  <= ~gid;
      op    <= sel_op;
      data  <= sel_data;
      shamt <= sel_shamt;
      id    <= gid;
      if (byp) begin
        resp_data <= sel_data;
        resp_id   <= gid;
        resp_err  <= (sel_op == 2'b11);
      end
    end else if (state == EXEC) begin
      resp_data <= result;
      resp_id   <= id;
      resp_err  <= (op == 2'b11);
    end
  end
endmodule

// File: tb/tb_shift_arbiter_32b.sv
// tb_shift_arbiter_32b: directed plus random checks of shift_arbiter_32b against a transaction-level model
`timescale 1ns/1ps
module tb_shift_arbiter_32b;
  localparam bit PRIO_INIT = 1'b0;
`ifdef SHIFT_ARB_ZERO_BYPASS_EN
  localparam int BL = 1;
`else
  localparam int BL = 2;
`endif
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready;
  logic [1:0]  req0_op, req1_op;
  logic [31:0] req0_data, req1_data;
  logic [4:0]  req0_shamt, req1_shamt;
  logic        resp_valid, resp_ready, resp_id, resp_err;
  logic [31:0] resp_data;
  int vectors = 0;
  int miscompares = 0;

  shift_arbiter_32b #(.PRIO_INIT(PRIO_INIT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req0_op(req0_op), .req0_data(req0_data), .req0_shamt(req0_shamt),
    .req1_op(req1_op), .req1_data(req1_data), .req1_shamt(req1_shamt),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_id(resp_id), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s);
    logic [31:0] r;
    case (op)
      2'b00:   r = d >> s;
      2'b01:   r = $signed(d) >>> s;
      2'b10:   r = d << s;
      default: r = d;
    endcase
    return r;
  endfunction

  // Transaction model: cycles until the response appears, plus the visible response registers
  bit          m_on = 1'b0;
  int          m_wait;
  bit          m_valid, m_id, m_err, m_prio, p_id, p_err;
  logic [31:0] m_data, p_data;
  logic [1:0]  m_g;
  logic [1:0]  g_op;
  logic [31:0] g_d;
  logic [4:0]  g_s;

  always @(negedge clk) begin
    m_g = (rst || m_wait != 0 || m_valid) ? 2'b00 :
          (req_valid == 2'b11) ? (m_prio ? 2'b10 : 2'b01) : req_valid;
    if (m_on) begin
      chk("req_ready", req_ready, m_g);
      chk("resp_valid", resp_valid, m_valid);
      chk("resp_data", resp_data, m_data);
      chk("resp_id", resp_id, m_id);
      chk("resp_err", resp_err, m_err);
    end
    if (rst) begin
      m_on = 1'b1; m_wait = 0; m_valid = 0; m_data = 0; m_id = 0; m_err = 0; m_prio = PRIO_INIT;
    end else if (m_valid) begin
      if (resp_ready) m_valid = 0;
    end else if (m_wait != 0) begin
      m_wait--;
      if (m_wait == 0) begin m_valid = 1; m_data = p_data; m_id = p_id; m_err = p_err; end
    end else if (m_g != 2'b00) begin
      p_id   = m_g[1];
      g_op   = p_id ? req1_op : req0_op;
      g_d    = p_id ? req1_data : req0_data;
      g_s    = p_id ? req1_shamt : req0_shamt;
      p_data = ref_shift(g_op, g_d, g_s);
      p_err  = (g_op == 2'b11);
      m_prio = !p_id;
      if (BL == 1 && (g_s == 0 || g_op == 2'b11)) begin
        m_valid = 1; m_data = p_data; m_id = p_id; m_err = p_err;
      end else m_wait = 1;
    end
  end

  task automatic issue(input bit id, input logic [1:0] op, input logic [31:0] d, input logic [4:0] s,
                       input int exp_lat, output logic [31:0] rd, output bit rid, output bit rerr);
    int n;
    bit ok;
    @(posedge clk); #1;
    if (id) begin req1_op = op; req1_data = d; req1_shamt = s; req_valid = 2'b10; end
    else    begin req0_op = op; req0_data = d; req0_shamt = s; req_valid = 2'b01; end
    ok = 0;
    for (n = 0; n < 20 && !ok; n++) begin @(negedge clk); ok = req_ready[id]; end
    chk("grant_seen", ok, 1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    ok = 0; n = 0;
    while (n < 10 && !ok) begin @(negedge clk); n++; ok = resp_valid; end
    chk("resp_seen", ok, 1);
    chk("latency", n, exp_lat);
    rd = resp_data; rid = resp_id; rerr = resp_err;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd, d0;
    bit rid, rerr, ok;
    int k, n;
    bit grants [3];
    rst = 1; req_valid = 0; resp_ready = 1;
    req0_op = 0; req0_data = 0; req0_shamt = 0; req1_op = 0; req1_data = 0; req1_shamt = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    issue(0, 2'b01, 32'h8000_00F0, 5'd4, 2, rd, rid, rerr);
    chk("sra_data", rd, 32'hF800_000F); chk("sra_id", rid, 0); chk("sra_err", rerr, 0);
    issue(1, 2'b10, 32'h0000_0001, 5'd31, 2, rd, rid, rerr);
    chk("sll_data", rd, 32'h8000_0000); chk("sll_id", rid, 1);
    issue(0, 2'b00, 32'hFFFF_FFFF, 5'd16, 2, rd, rid, rerr);
    chk("srl_data", rd, 32'h0000_FFFF);
    issue(0, 2'b11, 32'h1234_5678, 5'd5, BL, rd, rid, rerr);
    chk("ill_data", rd, 32'h1234_5678); chk("ill_err", rerr, 1);
    issue(1, 2'b00, 32'h0000_00F0, 5'd4, 2, rd, rid, rerr);
    chk("post_ill_data", rd, 32'h0000_000F); chk("post_ill_err", rerr, 0);
    issue(0, 2'b10, 32'hA5A5_0001, 5'd0, BL, rd, rid, rerr);
    chk("zero_shamt", rd, 32'hA5A5_0001);
    // contention: grant order must alternate starting from PRIO_INIT
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0; req_valid = 2'b11; resp_ready = 1;
    k = 0; n = 0;
    while (k < 3 && n < 40) begin
      @(negedge clk); n++;
      chk("ready_onehot", $countones(req_ready) <= 1, 1);
      if (req_ready != 0) begin grants[k] = req_ready[1]; k++; end
    end
    @(posedge clk); #1 req_valid = 0;
    chk("grant_count", k, 3);
    chk("grant0", grants[0], 0); chk("grant1", grants[1], 1); chk("grant2", grants[2], 0);
    repeat (4) @(posedge clk);
    // backpressure with a pending request from requester 1
    #1 resp_ready = 0; req0_op = 2'b00; req0_data = 32'hDEAD_BEEF; req0_shamt = 5'd8; req_valid = 2'b01;
    ok = 0;
    for (n = 0; n < 10 && !ok; n++) begin @(negedge clk); ok = req_ready[0]; end
    @(posedge clk); #1 req_valid = 2'b10; req1_op = 2'b01; req1_data = 32'h8000_0000; req1_shamt = 5'd1;
    ok = 0;
    for (n = 0; n < 10 && !ok; n++) begin @(negedge clk); ok = resp_valid; end
    chk("stall_resp", ok, 1);
    d0 = resp_data;
    chk("stall_data0", d0, 32'h00DE_ADBE);
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", resp_valid, 1); chk("stall_data", resp_data, d0); chk("stall_ready", req_ready, 0);
    end
    @(posedge clk); #1 resp_ready = 1;
    @(negedge clk);
    @(negedge clk);
    chk("pending_ready", req_ready, 2'b10);
    @(posedge clk); #1 req_valid = 0;
    repeat (4) @(posedge clk);
    // reset during EXEC
    #1 req0_op = 2'b00; req0_data = 32'hFFFF_0000; req0_shamt = 5'd3; req_valid = 2'b01;
    ok = 0;
    for (n = 0; n < 10 && !ok; n++) begin @(negedge clk); ok = req_ready[0]; end
    @(posedge clk); #1 rst = 1; req_valid = 0;
    @(posedge clk); #1 rst = 0; req_valid = 2'b11;
    @(negedge clk);
    chk("rst_exec_valid", resp_valid, 0);
    chk("rst_exec_prio", req_ready, PRIO_INIT ? 2'b10 : 2'b01);
    @(posedge clk); #1 req_valid = 0; resp_ready = 0;
    ok = 0;
    for (n = 0; n < 10 && !ok; n++) begin @(negedge clk); ok = resp_valid; end
    // reset during RESP
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0; resp_ready = 1;
    repeat (3) begin @(negedge clk); chk("rst_resp_valid", resp_valid, 0); end
    // random traffic
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      rst        = ($urandom_range(0, 60) == 0);
      req_valid  = 2'($urandom);
      req0_op    = 2'($urandom); req1_op = 2'($urandom);
      req0_data  = $urandom;     req1_data = $urandom;
      req0_shamt = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      req1_shamt = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1 rst = 0; req_valid = 0; resp_ready = 1;
    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
